// File: rtl/fc_argmax_layer_if.sv
// Control, memory-port and result-handshake signals of the FC argmax layer.
// The layer itself connects through the slave modport; the environment
// (controller, weight/activation/bias memories, consumer) uses master.
interface fc_argmax_layer_if #(
    parameter int unsigned N_IN  = 16,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIN_W = 18,
    parameter int unsigned W_W   = 9,
    parameter int unsigned ACC_W = 36
) ();
    localparam int unsigned DA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WA_W  = (N_OUT * DEPTH > 1) ? $clog2(N_OUT * DEPTH) : 1;
    localparam int unsigned CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                    start;
    logic                    relu_en;
    logic                    busy;
    logic [DA_W-1:0]         din_addr;
    logic [N_IN*DIN_W-1:0]   din;
    logic [WA_W-1:0]         w_addr;
    logic [N_IN*W_W-1:0]     w_data;
    logic [CLS_W-1:0]        b_addr;
    logic [W_W-1:0]          b_data;
    logic                    res_valid;
    logic                    res_ready;
    logic [CLS_W-1:0]        res_class;
    logic [ACC_W-1:0]        res_score;

    modport slave (
        input  start, relu_en, din, w_data, b_data, res_ready,
        output busy, din_addr, w_addr, b_addr, res_valid, res_class, res_score
    );

    modport master (
        output start, relu_en, din, w_data, b_data, res_ready,
        input  busy, din_addr, w_addr, b_addr, res_valid, res_class, res_score
    );
endinterface

// File: rtl/fc_argmax_layer.sv
// Fully-connected output layer with argmax.
// For each class c, accumulates N_IN lane products over DEPTH activation
// words, adds the class bias, optionally clamps negatives (ReLU) and keeps
// the running maximum. The winning class and its score are offered on a
// valid/ready result port. All three operand memories have 1-cycle latency.
//
// Pipeline (one term j = c*DEPTH+k per cycle):
//   issue : address j on din_addr/w_addr
//   data  : din/w_data valid, lane sum accumulated, b_addr = c
//   score : acc + bias (b_data valid), max update after the last k of c
module fc_argmax_layer #(
    parameter int unsigned N_IN  = 16,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIN_W = 18,
    parameter int unsigned W_W   = 9,
    parameter int unsigned ACC_W = 36
) (
    input  logic clk,
    input  logic rst,
    fc_argmax_layer_if.slave bus
);
    localparam int unsigned DA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WA_W  = (N_OUT * DEPTH > 1) ? $clog2(N_OUT * DEPTH) : 1;
    localparam int unsigned CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned T     = N_OUT * DEPTH;
    localparam int unsigned PW    = DIN_W + W_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    // Control / issue stage
    state_t             state_q;
    logic               busy_q;
    logic               res_valid_q;
    logic               relu_q;
    logic [WA_W-1:0]    j_q;
    logic [DA_W-1:0]    k_q;
    logic [CLS_W-1:0]   c_q;
    logic               iss_vld_q;

    // Data stage
    logic               dat_vld_q;
    logic [DA_W-1:0]    dat_k_q;
    logic [CLS_W-1:0]   dat_c_q;

    // Score stage
    logic               scr_vld_q;
    logic [CLS_W-1:0]   scr_c_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;

    // Running maximum (drives the result port directly)
    logic [ACC_W-1:0]   max_q;
    logic [ACC_W-1:0]   max_d;
    logic [CLS_W-1:0]   max_cls_q;
    logic [CLS_W-1:0]   max_cls_d;

    // Combinational arithmetic
    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      b_ext;
    logic [PW-1:0]      prod;
    logic [ACC_W-1:0]   lane_sum;
    logic [ACC_W-1:0]   score_raw;
    logic [ACC_W-1:0]   score;
    logic               fin;

    // Final class has been scored this cycle; result is complete at the edge.
    assign fin = scr_vld_q && (scr_c_q == CLS_W'(N_OUT - 1));

    // Control FSM: start handling, address issue, result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            relu_q      <= 1'b0;
            j_q         <= '0;
            k_q         <= '0;
            c_q         <= '0;
            iss_vld_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        relu_q    <= bus.relu_en;
                        busy_q    <= 1'b1;
                        j_q       <= '0;
                        k_q       <= '0;
                        c_q       <= '0;
                        iss_vld_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (j_q == WA_W'(T - 1)) begin
                        // Addresses hold their last value from here on.
                        iss_vld_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end else begin
                        j_q <= j_q + 1'b1;
                        if (k_q == DA_W'(DEPTH - 1)) begin
                            k_q <= '0;
                            c_q <= c_q + 1'b1;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fin) begin
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Lane sum: sign-extended per-lane products, each PW bits wide.
    always_comb begin
        a_ext    = '0;
        b_ext    = '0;
        prod     = '0;
        lane_sum = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            a_ext    = {{(PW - DIN_W){bus.din[i*DIN_W + DIN_W - 1]}}, bus.din[i*DIN_W +: DIN_W]};
            b_ext    = {{(PW - W_W){bus.w_data[i*W_W + W_W - 1]}}, bus.w_data[i*W_W +: W_W]};
            prod     = a_ext * b_ext;
            lane_sum = lane_sum + {{(ACC_W - PW){prod[PW-1]}}, prod};
        end
    end

    // Accumulator next value: k==0 restarts the sum so no clear cycle is needed.
    always_comb begin
        acc_d = acc_q;
        if (dat_vld_q) begin
            acc_d = (dat_k_q == '0) ? lane_sum : acc_q + lane_sum;
        end
    end

    // Score with bias and optional ReLU; strict compare keeps the lower index on ties.
    always_comb begin
        score_raw = acc_q + {{(ACC_W - W_W){bus.b_data[W_W-1]}}, bus.b_data};
        score     = (relu_q && score_raw[ACC_W-1]) ? '0 : score_raw;
        max_d     = max_q;
        max_cls_d = max_cls_q;
        if (scr_vld_q) begin
            if ((scr_c_q == '0) || ($signed(score) > $signed(max_q))) begin
                max_d     = score;
                max_cls_d = scr_c_q;
            end
        end
    end

    // Datapath pipeline registers: data stage, score stage, accumulator, maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_vld_q <= 1'b0;
            dat_k_q   <= '0;
            dat_c_q   <= '0;
            scr_vld_q <= 1'b0;
            scr_c_q   <= '0;
            acc_q     <= '0;
            max_q     <= '0;
            max_cls_q <= '0;
        end else begin
            dat_vld_q <= iss_vld_q;
            dat_k_q   <= k_q;
            dat_c_q   <= c_q;
            scr_vld_q <= dat_vld_q && (dat_k_q == DA_W'(DEPTH - 1));
            scr_c_q   <= dat_c_q;
            acc_q     <= acc_d;
            max_q     <= max_d;
            max_cls_q <= max_cls_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.din_addr  = k_q;
    assign bus.w_addr    = j_q;
    // Class of the term in the data stage, so its bias arrives in the score cycle.
    assign bus.b_addr    = dat_c_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_class = max_cls_q;
    assign bus.res_score = max_q;
endmodule

// File: tb/tb_fc_argmax_layer.sv
// Directed testbench for fc_argmax_layer with behavioural 1-cycle memories.
module tb_fc_argmax_layer;
    localparam int unsigned N_IN  = 16;
    localparam int unsigned N_OUT = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DIN_W = 18;
    localparam int unsigned W_W   = 9;
    localparam int unsigned ACC_W = 36;
    localparam int unsigned T     = N_OUT * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc;

    fc_argmax_layer_if #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH),
        .DIN_W(DIN_W), .W_W(W_W), .ACC_W(ACC_W)
    ) bus_if ();

    fc_argmax_layer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH),
        .DIN_W(DIN_W), .W_W(W_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    logic [N_IN*DIN_W-1:0] din_mem [DEPTH];
    logic [N_IN*W_W-1:0]   w_mem   [T];
    logic [W_W-1:0]        b_mem   [N_OUT];

    // Synchronous read memories, one cycle of latency.
    always @(posedge clk) begin
        bus_if.din    <= din_mem[bus_if.din_addr];
        bus_if.w_data <= w_mem[bus_if.w_addr];
        bus_if.b_data <= b_mem[bus_if.b_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int dv, input int wv, input int bv);
        logic [DIN_W-1:0] d;
        logic [W_W-1:0]   w;
        d = DIN_W'(dv);
        w = W_W'(wv);
        for (int k = 0; k < int'(DEPTH); k++)
            for (int i = 0; i < int'(N_IN); i++) din_mem[k][i*DIN_W +: DIN_W] = d;
        for (int r = 0; r < int'(T); r++)
            for (int i = 0; i < int'(N_IN); i++) w_mem[r][i*W_W +: W_W] = w;
        for (int c = 0; c < int'(N_OUT); c++) b_mem[c] = W_W'(bv);
    endtask

    task automatic set_class_w(input int c, input int wv);
        logic [W_W-1:0] w;
        w = W_W'(wv);
        for (int k = 0; k < int'(DEPTH); k++)
            for (int i = 0; i < int'(N_IN); i++) w_mem[c*DEPTH + k][i*W_W +: W_W] = w;
    endtask

    task automatic launch(input logic relu);
        bus_if.relu_en = relu;
        bus_if.start   = 1'b1;
        tick();
        bus_if.start   = 1'b0;
        bus_if.relu_en = 1'b0;
    endtask

    // Advance until res_valid, bounded; returns the cycle number it was seen in.
    task automatic wait_valid(input int cyc0, output int cyc_at);
        cyc_at = cyc0;
        while (bus_if.res_valid !== 1'b1 && cyc_at < cyc0 + 200) begin
            tick();
            cyc_at++;
        end
    endtask

    task automatic handshake();
        bus_if.res_ready = 1'b1;
        tick();
        bus_if.res_ready = 1'b0;
        check("hs_valid_drop", 64'(bus_if.res_valid), 64'd0);
        check("hs_busy_drop", 64'(bus_if.busy), 64'd0);
    endtask

    task automatic run_and_check(input string tag, input logic relu,
                                 input int exp_cls, input logic [ACC_W-1:0] exp_score);
        int c_at;
        launch(relu);
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd1);
        wait_valid(1, c_at);
        check({tag, "_latency"}, 64'(c_at), 64'd43);
        check({tag, "_class"}, 64'(bus_if.res_class), 64'(exp_cls));
        check({tag, "_score"}, 64'(bus_if.res_score), 64'(exp_score));
        handshake();
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.relu_en   = 1'b0;
        bus_if.res_ready = 1'b0;
        set_all(0, 0, 0);

        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_valid", 64'(bus_if.res_valid), 64'd0);
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_waddr", 64'(bus_if.w_addr), 64'd0);
        check("rst_daddr", 64'(bus_if.din_addr), 64'd0);
        check("rst_baddr", 64'(bus_if.b_addr), 64'd0);
        check("rst_class", 64'(bus_if.res_class), 64'd0);
        check("rst_score", 64'(bus_if.res_score), 64'd0);
        tick();

        // 1: all zero, ReLU on
        run_and_check("zero", 1'b1, 0, 36'd0);
        tick();

        // 2: class 7 weights 1, din 1 -> 16 lanes * 4 words = 64; address sequence
        set_all(1, 0, 0);
        set_class_w(7, 1);
        launch(1'b0);
        for (int j = 0; j < int'(T); j++) begin
            check("seq_waddr", 64'(bus_if.w_addr), 64'(j));
            check("seq_daddr", 64'(bus_if.din_addr), 64'(j % DEPTH));
            tick();
        end
        wait_valid(41, cyc);
        check("c7_latency", 64'(cyc), 64'd43);
        check("c7_class", 64'(bus_if.res_class), 64'd7);
        check("c7_score", 64'(bus_if.res_score), 64'd64);
        handshake();

        // 3: biases -5, class 3 = -1, raw then ReLU
        set_all(1, 0, -5);
        b_mem[3] = W_W'(-1);
        run_and_check("neg_raw", 1'b0, 3, 36'hF_FFFF_FFFF);
        run_and_check("neg_relu", 1'b1, 0, 36'd0);

        // 4: tie between classes 2 and 5 at 100, others 50
        set_all(1, 0, 50);
        set_class_w(2, 1);  b_mem[2] = W_W'(36);
        set_class_w(5, 2);  b_mem[5] = W_W'(-28);
        run_and_check("tie", 1'b0, 2, 36'd100);

        // 5: extremes: (-2^17)(-2^8)=2^25, *16*4 = 2^31, minus 256
        set_all(-131072, -256, -256);
        run_and_check("extreme", 1'b0, 0, 36'd2147483392);

        // 6a: backpressure, start ignored while the result is held
        set_all(1, 0, 0);
        set_class_w(7, 1);
        launch(1'b0);
        wait_valid(1, cyc);
        check("bp_latency", 64'(cyc), 64'd43);
        for (int i = 0; i < 20; i++) begin
            bus_if.start = (i == 5);
            tick();
            bus_if.start = 1'b0;
            check("bp_valid", 64'(bus_if.res_valid), 64'd1);
            check("bp_class", 64'(bus_if.res_class), 64'd7);
            check("bp_score", 64'(bus_if.res_score), 64'd64);
            check("bp_busy", 64'(bus_if.busy), 64'd1);
        end
        check("bp_waddr_hold", 64'(bus_if.w_addr), 64'(T - 1));
        handshake();
        tick();

        // 6b: reset at cycle 15 of a run, then a clean rerun
        launch(1'b0);
        for (int i = 1; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 64'(bus_if.res_valid), 64'd0);
        check("mrst_busy", 64'(bus_if.busy), 64'd0);
        check("mrst_waddr", 64'(bus_if.w_addr), 64'd0);
        check("mrst_daddr", 64'(bus_if.din_addr), 64'd0);
        check("mrst_class", 64'(bus_if.res_class), 64'd0);
        check("mrst_score", 64'(bus_if.res_score), 64'd0);
        tick();
        check("mrst_idle_busy", 64'(bus_if.busy), 64'd0);
        check("mrst_idle_waddr", 64'(bus_if.w_addr), 64'd0);
        run_and_check("after_rst", 1'b0, 7, 36'd64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
